debug_frame_uart_tx: RTL and testbench

UART transmitter that sits downstream of the single-cycle MIPS datapath on the DE2 board. It captures the six 8-bit debug bytes the processor exposes for display (`w_d0x0`..`w_d0x5`) and serializes them as one framed packet on `UART_TXD`, so a host can log processor state per instruction. A frame is a sync byte, the six data bytes and an XOR checksum, sent as 8N1.

---
 rtl/debug_frame_uart_tx.sv | 152 +++++++++++++++
 tb/tb_debug_frame_uart_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_frame_uart_tx.sv
// Serializes a snapshot of six debug bytes as one 8N1 UART frame:
// sync byte, six data bytes, XOR checksum of the data bytes.
module debug_frame_uart_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  d_x0,
  input  logic [7:0]  d_x1,
  input  logic [7:0]  d_x2,
  input  logic [7:0]  d_x3,
  input  logic [7:0]  d_x4,
  input  logic [7:0]  d_x5,
  output logic        UART_TXD,
  output logic        busy,
  output logic        done,
  output logic [15:0] frames_sent
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  logic [1:0]  state_q,  state_d;
  logic [15:0] timer_q,  timer_d;
  logic [2:0]  bit_q,    bit_d;
  logic [2:0]  byte_q,   byte_d;
  logic [47:0] snap_q,   snap_d;
  logic        txd_q,    txd_d;
  logic        busy_q,   busy_d;
  logic        done_q,   done_d;
  logic [15:0] frames_q, frames_d;

  logic [7:0]  chk;
  logic [7:0]  cur_byte;
  logic [2:0]  nxt_bit;
  logic        bit_end;

  assign chk      = snap_q[7:0] ^ snap_q[15:8] ^ snap_q[23:16]
                  ^ snap_q[31:24] ^ snap_q[39:32] ^ snap_q[47:40];
  assign bit_end  = (timer_q == BIT_LAST);
  assign nxt_bit  = bit_q + 3'd1;

  always_comb begin
    case (byte_q)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = snap_q[7:0];
      3'd2:    cur_byte = snap_q[15:8];
      3'd3:    cur_byte = snap_q[23:16];
      3'd4:    cur_byte = snap_q[31:24];
      3'd5:    cur_byte = snap_q[39:32];
      3'd6:    cur_byte = snap_q[47:40];
      default: cur_byte = chk;
    endcase
  end

  // The line value for the next bit is registered at the bit boundary,
  // so UART_TXD changes exactly one cycle after the deciding edge.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 16'd1;
    bit_d    = bit_q;
    byte_d   = byte_q;
    snap_d   = snap_q;
    txd_d    = txd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    frames_d = frames_q;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (start) begin
          snap_d  = {d_x5, d_x4, d_x3, d_x2, d_x1, d_x0};
          state_d = S_START;
          byte_d  = '0;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          timer_d = '0;
          state_d = S_DATA;
          bit_d   = '0;
          txd_d   = cur_byte[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          timer_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = nxt_bit;
            txd_d = cur_byte[nxt_bit];
          end
        end
      end
      default: begin
        if (bit_end) begin
          timer_d = '0;
          if (byte_q == 3'd7) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            frames_d = frames_q + 16'd1;
          end else begin
            byte_d  = byte_q + 3'd1;
            state_d = S_START;
            txd_d   = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      snap_q   <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      snap_q   <= snap_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      frames_q <= frames_d;
    end
  end

  assign UART_TXD    = txd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_debug_frame_uart_tx.sv
// Randomized scoreboard bench for debug_frame_uart_tx: a line decoder and a
// done monitor pop expected bytes / frame counts pushed by the stimulus.
module tb_debug_frame_uart_tx;

  localparam int         CPB  = 4;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  d [6];
  logic        UART_TXD, busy, done;
  logic [15:0] frames_sent;

  debug_frame_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC)) dut (
    .CLOCK_50(clk), .rst_n(rst_n), .start(start),
    .d_x0(d[0]), .d_x1(d[1]), .d_x2(d[2]), .d_x3(d[3]), .d_x4(d[4]), .d_x5(d[5]),
    .UART_TXD(UART_TXD), .busy(busy), .done(done), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_fs[$];
  logic [15:0] exp_cnt = '0;
  int          start_cyc[$];
  int          done_cyc[$];

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  // Reference model: a frame is the sync byte, the six bytes, their XOR.
  task automatic push_frame();
    logic [7:0] x;
    x = '0;
    exp_bytes.push_back(SYNC);
    for (int i = 0; i < 6; i++) begin
      exp_bytes.push_back(d[i]);
      x = x ^ d[i];
    end
    exp_bytes.push_back(x);
    exp_cnt = exp_cnt + 16'd1;
    exp_fs.push_back(exp_cnt);
  endtask

  // Line decoder and done/busy monitor, sampled mid-cycle.
  int         cyc = 0;
  bit         rx_act = 0;
  int         rx_t = 0;
  int         rx_n = 0;
  logic [7:0] rx_byte;
  int         bcnt = 0;
  bit         prev_done = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      rx_act = 0; rx_n = 0; bcnt = 0; prev_done = 0;
    end else begin
      if (!rx_act && UART_TXD == 1'b0) begin
        rx_act = 1; rx_t = 0;
        if (rx_n == 0) start_cyc.push_back(cyc);
      end
      if (rx_act) begin
        if (rx_t % CPB == CPB / 2) begin
          int k;
          k = rx_t / CPB;
          if (k >= 1 && k <= 8) rx_byte[k-1] = UART_TXD;
          if (k == 9) begin
            check("stop_bit", int'(UART_TXD), 1);
            if (exp_bytes.size() == 0) check("unexpected_byte", int'(rx_byte), -1);
            else check($sformatf("byte%0d", rx_n), int'(rx_byte), int'(exp_bytes.pop_front()));
            rx_act = 0;
            rx_n = (rx_n + 1) % 8;
          end
        end
        rx_t++;
      end
      if (busy) bcnt++;
      if (done) begin
        check("done_width", int'(prev_done), 0);
        check("busy_len", bcnt, 80 * CPB);
        check("busy_at_done", int'(busy), 0);
        if (start_cyc.size() > 0) check("frame_len", cyc - start_cyc[$], 80 * CPB);
        if (exp_fs.size() == 0) check("unexpected_done", int'(frames_sent), -1);
        else check("frames_sent", int'(frames_sent), int'(exp_fs.pop_front()));
        done_cyc.push_back(cyc);
        bcnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    start = 1'b0;
    exp_bytes.delete(); exp_fs.delete(); start_cyc.delete(); done_cyc.delete();
    exp_cnt = '0;
    cycles(3);
    rst_n = 1'b1;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 6; i++) d[i] = 8'($urandom);
  endtask

  // Drives a single-cycle start while idle; the frame is accepted at the next edge.
  task automatic send();
    start = 1'b1;
    push_frame();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check("done_timeout", 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) d[i] = '0;

    // reset state and quiet idle line
    do_reset();
    @(negedge clk);
    check("rst_txd", int'(UART_TXD), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_frames", int'(frames_sent), 0);
    begin
      int idle_bad;
      idle_bad = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (UART_TXD !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_bad++;
      end
      check("idle_quiet", idle_bad, 0);
    end

    // single known frame: A5 01 02 04 08 10 20 3F
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) d[i] = 8'(1 << i);
    send();
    wait_done(100 * CPB);
    @(posedge clk); #1;
    check("single_frames", int'(frames_sent), 1);

    // snapshot isolation and ignored starts while busy
    do_reset();
    for (int i = 0; i < 6; i++) d[i] = 8'hFF;
    send();
    cycles(10 * CPB);
    for (int i = 0; i < 6; i++) d[i] = 8'h00;
    for (int p = 0; p < 3; p++) begin
      start = 1'b1; cycles(1); start = 1'b0; cycles(7);
    end
    wait_done(100 * CPB);
    cycles(20 * CPB);
    check("snap_frames", int'(frames_sent), 1);
    check("snap_idle_busy", int'(busy), 0);

    // back-to-back with start held high
    do_reset();
    rand_inputs();
    send();
    start = 1'b1;
    rand_inputs();
    wait_done(100 * CPB);
    push_frame();
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100 * CPB);
    @(posedge clk); #1;
    check("b2b_frames", int'(frames_sent), 2);
    if (start_cyc.size() == 2 && done_cyc.size() == 2)
      check("b2b_gap", start_cyc[1] - done_cyc[0], 1);
    else
      check("b2b_counts", start_cyc.size() * 16 + done_cyc.size(), 8'h22);

    // asynchronous reset during data bits of byte 3
    do_reset();
    rand_inputs();
    send();
    cycles(34 * CPB);
    #2 rst_n = 1'b0;
    exp_bytes.delete(); exp_fs.delete(); start_cyc.delete(); done_cyc.delete();
    exp_cnt = '0;
    #1;
    check("abort_txd", int'(UART_TXD), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_frames", int'(frames_sent), 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(5);
    check("abort_stays_idle", int'(busy), 0);
    rand_inputs();
    send();
    wait_done(100 * CPB);

    // frame counter wrap
    do_reset();
    @(negedge clk);
    force dut.frames_q = 16'hFFFF;
    @(negedge clk);
    release dut.frames_q;
    exp_cnt = 16'hFFFF;
    @(posedge clk); #1;
    rand_inputs();
    send();
    wait_done(100 * CPB);
    @(posedge clk); #1;
    check("wrap_frames", int'(frames_sent), 0);

    // randomized frames with random gaps and mid-frame input churn
    for (int f = 0; f < 6; f++) begin
      cycles($urandom_range(0, 5));
      rand_inputs();
      send();
      cycles($urandom_range(1, 60 * CPB));
      rand_inputs();
      wait_done(100 * CPB);
      @(posedge clk); #1;
    end

    cycles(5);
    check("bytes_drained", exp_bytes.size(), 0);
    check("frames_drained", exp_fs.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
